// File: rtl/stage_4_mem.sv
// MEM stage of the five-stage pipeline: valid/allow slot, load-data alignment, WB and ID-bypass buses.
// Define MEM_SUBWORD_LD_EN for ld.b/ld.h/ld.bu/ld.hu lane extraction; otherwise all loads return the word.
module stage_4_mem (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_3,
    output logic        allow_4,
    output logic        valid_4,
    input  logic        allow_5,
    input  logic [73:0] stage_3_to_4,
    input  logic [31:0] data_sram_rdata,
    output logic [69:0] stage_4_to_5,
    output logic [37:0] mem_fwd
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned LDT_W  = 3;
    localparam int unsigned FWD_W  = 1 + REG_W + DATA_W;

    localparam logic READYGO_4 = 1'b1;

    typedef struct packed {
        logic [LDT_W-1:0]  ld_type;
        logic              res_from_mem;
        logic              rf_we;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] pc;
    } ex_mem_t;

    ex_mem_t           payload_q, payload_d;
    logic              valid_4_q, valid_4_d;
    logic              hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0] rdata_hold_q, rdata_hold_d;

    logic [DATA_W-1:0] eff_rdata;
    logic [DATA_W-1:0] load_value;
    logic [DATA_W-1:0] final_result;
    logic              fwd_we;

    assign allow_4 = !valid_4_q || (READYGO_4 && allow_5);
    assign valid_4 = valid_4_q;

    // Slot advance plus capture of SRAM read data on the first stalled cycle of a load
    always_comb begin
        payload_d    = payload_q;
        valid_4_d    = valid_4_q;
        hold_valid_d = hold_valid_q;
        rdata_hold_d = rdata_hold_q;

        if (allow_4) begin
            valid_4_d = valid_3;
        end
        if (valid_3 && allow_4) begin
            payload_d = ex_mem_t'(stage_3_to_4);
        end

        if (valid_4_q && allow_5) begin
            hold_valid_d = 1'b0;
        end else if (valid_4_q && payload_q.res_from_mem && !hold_valid_q && !allow_5) begin
            hold_valid_d = 1'b1;
            rdata_hold_d = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            payload_q    <= '0;
            valid_4_q    <= 1'b0;
            hold_valid_q <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            payload_q    <= payload_d;
            valid_4_q    <= valid_4_d;
            hold_valid_q <= hold_valid_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    assign eff_rdata = hold_valid_q ? rdata_hold_q : data_sram_rdata;

`ifdef MEM_SUBWORD_LD_EN
    logic [1:0]  addr_lo;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Misaligned halves fall back to the containing aligned half
    always_comb begin
        addr_lo    = payload_q.alu_result[1:0];
        ld_byte    = eff_rdata[{addr_lo, 3'b000} +: 8];
        ld_half    = addr_lo[1] ? eff_rdata[31:16] : eff_rdata[15:0];
        load_value = eff_rdata;
        case (payload_q.ld_type)
            3'b001:  load_value = {{24{ld_byte[7]}}, ld_byte};
            3'b010:  load_value = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_value = {24'h000000, ld_byte};
            3'b110:  load_value = {16'h0000, ld_half};
            default: load_value = eff_rdata;
        endcase
    end
`else
    logic [LDT_W-1:0] unused_ld_type;

    assign unused_ld_type = payload_q.ld_type;
    assign load_value     = eff_rdata;
`endif

    assign final_result = payload_q.res_from_mem ? load_value : payload_q.alu_result;

    // WB applies its own valid mask, so this bus is deliberately unmasked
    assign stage_4_to_5 = {payload_q.rf_we, payload_q.dest, final_result, payload_q.pc};

    assign fwd_we  = valid_4_q && payload_q.rf_we && (payload_q.dest != '0);
    assign mem_fwd = fwd_we ? {1'b1, payload_q.dest, final_result} : FWD_W'(0);

endmodule

// File: tb/tb_stage_4_mem.sv
// Bench for stage_4_mem: vector table streamed back-to-back through a scoreboard, plus stall/reset sequences.
module tb_stage_4_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_3;
    logic        allow_4;
    logic        valid_4;
    logic        allow_5;
    logic [73:0] stage_3_to_4;
    logic [31:0] data_sram_rdata;
    logic [69:0] stage_4_to_5;
    logic [37:0] mem_fwd;

    stage_4_mem dut (
        .clk             (clk),
        .reset           (reset),
        .valid_3         (valid_3),
        .allow_4         (allow_4),
        .valid_4         (valid_4),
        .allow_5         (allow_5),
        .stage_3_to_4    (stage_3_to_4),
        .data_sram_rdata (data_sram_rdata),
        .stage_4_to_5    (stage_4_to_5),
        .mem_fwd         (mem_fwd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ld;
        logic        rfm;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] exp_sub;
        logic [31:0] exp_w;
    } vec_t;

    typedef struct {
        logic [69:0] s45;
        logic [37:0] fwd;
    } exp_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [73:0] pack(input logic [2:0] ld, input logic rfm, input logic we,
                                         input logic [4:0] dest, input logic [31:0] alu,
                                         input logic [31:0] pc);
        return {ld, rfm, we, dest, alu, pc};
    endfunction

    function automatic exp_t mk_exp(input logic we, input logic [4:0] dest,
                                    input logic [31:0] res, input logic [31:0] pc);
        exp_t e;
        e.s45 = {we, dest, res, pc};
        e.fwd = (we && dest != 5'd0) ? {1'b1, dest, res} : 38'd0;
        return e;
    endfunction

    // Scoreboard: an instruction is retired on any cycle WB accepts it
    always @(negedge clk) begin
        if (!reset && valid_4 && allow_5) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_retire", 70'd1, 70'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_stage_4_to_5", stage_4_to_5, e.s45);
                check("sb_mem_fwd", 70'(mem_fwd), 70'(e.fwd));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        exp_t        stall_exp;

        vecs[0]  = '{3'b001, 1'b1, 1'b1, 5'd5,  32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80, 32'h80FF_1234};
        vecs[1]  = '{3'b110, 1'b1, 1'b1, 5'd6,  32'h0000_2002, 32'hBEEF_0001, 32'h0000_BEEF, 32'hBEEF_0001};
        vecs[2]  = '{3'b010, 1'b1, 1'b1, 5'd6,  32'h0000_2002, 32'hBEEF_0001, 32'hFFFF_BEEF, 32'hBEEF_0001};
        vecs[3]  = '{3'b101, 1'b1, 1'b1, 5'd7,  32'h0000_3001, 32'h0000_A500, 32'h0000_00A5, 32'h0000_A500};
        vecs[4]  = '{3'b001, 1'b1, 1'b1, 5'd7,  32'h0000_3001, 32'h0000_A500, 32'hFFFF_FFA5, 32'h0000_A500};
        vecs[5]  = '{3'b010, 1'b1, 1'b1, 5'd8,  32'h0000_4003, 32'h7FFF_8000, 32'h0000_7FFF, 32'h7FFF_8000};
        vecs[6]  = '{3'b110, 1'b1, 1'b1, 5'd8,  32'h0000_4001, 32'h1234_8001, 32'h0000_8001, 32'h1234_8001};
        vecs[7]  = '{3'b000, 1'b1, 1'b1, 5'd12, 32'h0000_5000, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[8]  = '{3'b111, 1'b1, 1'b1, 5'd13, 32'h0000_5001, 32'h0102_0304, 32'h0102_0304, 32'h0102_0304};
        vecs[9]  = '{3'b001, 1'b0, 1'b1, 5'd9,  32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[10] = '{3'b000, 1'b0, 1'b1, 5'd0,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678};
        vecs[11] = '{3'b000, 1'b0, 1'b0, 5'd3,  32'h0BAD_F00D, 32'h0000_0000, 32'h0BAD_F00D, 32'h0BAD_F00D};
        vecs[12] = '{3'b000, 1'b0, 1'b1, 5'd31, 32'h0000_0011, 32'h5555_5555, 32'h0000_0011, 32'h0000_0011};
        vecs[13] = '{3'b000, 1'b0, 1'b1, 5'd1,  32'h0000_0022, 32'hAAAA_AAAA, 32'h0000_0022, 32'h0000_0022};

        reset           = 1'b1;
        valid_3         = 1'b0;
        allow_5         = 1'b1;
        stage_3_to_4    = '0;
        data_sram_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid_4", 70'(valid_4), 70'd0);
        check("rst_allow_4", 70'(allow_4), 70'd1);
        check("rst_stage_4_to_5", stage_4_to_5, 70'd0);
        check("rst_mem_fwd", 70'(mem_fwd), 70'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Back-to-back stream: rdata for vector i-1 is present while vector i is offered
        for (int i = 0; i <= NVEC; i++) begin
            @(posedge clk); #1;
            allow_5 = 1'b1;
            if (i < NVEC) begin
                valid_3      = 1'b1;
                stage_3_to_4 = pack(vecs[i].ld, vecs[i].rfm, vecs[i].we, vecs[i].dest,
                                    vecs[i].alu, 32'h1000_0000 + 32'(4 * i));
`ifdef MEM_SUBWORD_LD_EN
                res = vecs[i].exp_sub;
`else
                res = vecs[i].exp_w;
`endif
                sb.push_back(mk_exp(vecs[i].we, vecs[i].dest, res, 32'h1000_0000 + 32'(4 * i)));
            end else begin
                valid_3 = 1'b0;
            end
            data_sram_rdata = (i > 0) ? vecs[i-1].rdata : 32'h0;
            if (i > 0) begin
                @(negedge clk);
                check("b2b_valid_4", 70'(valid_4), 70'd1);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("stream_drained", 70'(sb.size()), 70'd0);
        check("idle_valid_4", 70'(valid_4), 70'd0);

        // Stall: ld.w held three cycles while the SRAM output changes underneath
        @(posedge clk); #1;
        valid_3      = 1'b1;
        allow_5      = 1'b1;
        stage_3_to_4 = pack(3'b000, 1'b1, 1'b1, 5'd10, 32'h0000_6000, 32'h0000_2000);
        stall_exp    = mk_exp(1'b1, 5'd10, 32'h1111_1111, 32'h0000_2000);
        sb.push_back(stall_exp);
        @(posedge clk); #1;
        valid_3         = 1'b0;
        allow_5         = 1'b0;
        data_sram_rdata = 32'h1111_1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_allow_4", 70'(allow_4), 70'd0);
            check("stall_valid_4", 70'(valid_4), 70'd1);
            check("stall_stage_4_to_5", stage_4_to_5, stall_exp.s45);
            check("stall_mem_fwd", 70'(mem_fwd), 70'(stall_exp.fwd));
            @(posedge clk); #1;
            data_sram_rdata = 32'h2222_2222;
        end
        // Leave and enter on the same edge: the new load must see live data, not the hold
        allow_5      = 1'b1;
        valid_3      = 1'b1;
        stage_3_to_4 = pack(3'b000, 1'b1, 1'b1, 5'd14, 32'h0000_7000, 32'h0000_2004);
        sb.push_back(mk_exp(1'b1, 5'd14, 32'h3333_3333, 32'h0000_2004));
        @(posedge clk); #1;
        valid_3         = 1'b0;
        data_sram_rdata = 32'h3333_3333;
        @(posedge clk); #1;
        @(negedge clk);
        check("after_stall_valid_4", 70'(valid_4), 70'd0);
        check("after_stall_drained", 70'(sb.size()), 70'd0);

        // Reset during a load stall discards the held read data
        @(posedge clk); #1;
        valid_3      = 1'b1;
        stage_3_to_4 = pack(3'b000, 1'b1, 1'b1, 5'd15, 32'h0000_8000, 32'h0000_3000);
        @(posedge clk); #1;
        valid_3         = 1'b0;
        allow_5         = 1'b0;
        data_sram_rdata = 32'h4444_4444;
        @(posedge clk); #1;
        reset           = 1'b1;
        data_sram_rdata = 32'h5555_5555;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_valid_4", 70'(valid_4), 70'd0);
        check("midrst_allow_4", 70'(allow_4), 70'd1);
        check("midrst_stage_4_to_5", stage_4_to_5, 70'd0);
        check("midrst_mem_fwd", 70'(mem_fwd), 70'd0);
        @(posedge clk); #1;
        valid_3      = 1'b1;
        allow_5      = 1'b1;
        stage_3_to_4 = pack(3'b000, 1'b1, 1'b1, 5'd16, 32'h0000_9000, 32'h0000_3004);
        sb.push_back(mk_exp(1'b1, 5'd16, 32'h6666_6666, 32'h0000_3004));
        @(posedge clk); #1;
        valid_3         = 1'b0;
        data_sram_rdata = 32'h6666_6666;
        @(posedge clk); #1;
        @(negedge clk);
        check("final_drained", 70'(sb.size()), 70'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
